uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//   Memory-mapped UART transmitter; a bus responder on the CPU peripheral bus (address bit 30 set).
//   The CPU writes a byte to TXD and the block serialises it on tx as 8N1, LSB first.
//   A sticky done flag in CON raises irq, which feeds the CPU's exception/IRQ path.
// PARAMETERS
//   BAUD_DIV   10417   clk cycles per bit (100 MHz / 9600 baud); legal range >= 2
//   BASE_TXD   8'h18   addr[7:0] offset of TXD register
//   BASE_CON   8'h20   addr[7:0] offset of CON register
// PORTS
//   clk    in   1   system clock, all state on posedge
//   reset  in   1   synchronous, active-low reset
//   rd     in   1   bus read strobe (MemRd & addr[30], qualified by the CPU)
//   wr     in   1   bus write strobe (MemWr & addr[30], qualified by the CPU)
//   addr   in   32  byte address; only addr[7:0] decoded
//   wdata  in   32  write data; TXD uses [7:0], CON uses [0]
//   rdata  out  32  read data, combinational, 32'd0 when not selected or rd=0
//   tx     out  1   serial output, idle high
//   irq    out  1   tx_done & ie
// BEHAVIOUR
//   Reset (reset=0 at posedge): state=IDLE, tx=1, ie=0, tx_done=0, shift=0, bit/baud counters=0.
//   CON read value: {27'd0, busy[4], 1'b0, tx_done[2], 1'b0, ie[0]}; busy = (state!=IDLE).
//   TXD read value: {24'd0, last byte accepted}.
//   CON write: ie <= wdata[0]; other bits read-only.
//   CON read (rd & CON selected): clears tx_done at that edge; a set in the same cycle wins (stays 1).
//   TXD write accepted only if state==IDLE at that edge; otherwise dropped silently, no flag.
//   FSM: IDLE -> START (on accepted write) -> DATA (8 bits, LSB first) -> STOP -> IDLE.
//   Each state bit lasts exactly BAUD_DIV cycles; baud counter counts 0..BAUD_DIV-1, reloads 0 on wrap.
//   tx is registered: write accepted at edge N -> tx=0 from edge N; frame is 10*BAUD_DIV cycles.
//   On last cycle of STOP: state->IDLE, tx_done<=1 at the same edge; a TXD write in that cycle is dropped.
//   irq combinational from registers; held until tx_done cleared or ie=0.
//   Reset mid-frame: frame aborted, tx returns to 1 at the reset edge, no done flag.
//   rd and wr both high on same address: write takes effect; read returns pre-edge value.
// CONFIGURATION
//   UART_PARITY_EN defined: PARITY state inserted between DATA and STOP carrying even parity
//     (XOR of the 8 data bits); frame = 11*BAUD_DIV cycles; CON[3] reads 1.
//   UART_PARITY_EN undefined: 8N1 as above, 10*BAUD_DIV cycles; CON[3] reads 0.
// STRUCTURE
//   Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), TXD/CON offset defaults,
//     CON bit indices (IE=0, DONE=2, PAR=3, BUSY=4).
//   Sub-module uart_baud_gen: counter with clear input, emits 1-cycle tick on BAUD_DIV-1;
//     FSM clears it on frame start so the start bit is full length.
//   Top holds register decode, FSM, 8-bit shift register, 3-bit bit counter.
// TESTING  (BAUD_DIV=4 in bench)
//   Reset: hold reset=0 2 cycles -> tx=1, irq=0, CON reads 32'h0.
//   Write TXD=8'hA5 -> tx: 0,1,0,1,0,0,1,0,1,1 each 4 cycles; CON[4]=1 during, 40 cycles total.
//   CON=1 then send 8'h3C -> irq=1 after stop bit, CON reads 32'h5; next cycle irq=0, CON=32'h1.
//   Write 8'hFF while busy -> ignored; line shows only first byte; TXD reads first byte.
//   Assert reset=0 at cycle 15 of a frame -> tx=1 next edge, CON=0, no irq.
//   UART_PARITY_EN, send 8'h07 -> parity bit 1 before stop; frame 44 cycles; CON[3]=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
// States, register offsets and CON bit positions.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [7:0] TXD_OFS = 8'h18;
  localparam logic [7:0] CON_OFS = 8'h20;

  localparam int CON_IE   = 0;
  localparam int CON_DONE = 2;
  localparam int CON_PAR  = 3;
  localparam int CON_BUSY = 4;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 while enabled and pulses tick_o
// on the last count; clr_i restarts the period from zero.
module uart_baud_gen #(
  parameter int DIV = 10417
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || tick_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter (8N1, LSB first) with sticky done irq.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int         BAUD_DIV = 10417,
  parameter logic [7:0] BASE_TXD = TXD_OFS,
  parameter logic [7:0] BASE_CON = CON_OFS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       ie_q, ie_d;
  logic       done_q, done_d;

  logic txd_sel, con_sel, busy, accept, tick;
  logic [31:0] con_val;
  logic unused_bits;

  assign unused_bits = ^{addr[31:8], wdata[31:8]};

  assign txd_sel = (addr[7:0] == BASE_TXD);
  assign con_sel = (addr[7:0] == BASE_CON);
  assign busy    = (state_q != ST_IDLE);
  assign accept  = wr & txd_sel & ~busy;

  uart_baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (accept),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    ie_d    = ie_q;
    done_d  = done_q;

    if (rd && con_sel)
      done_d = 1'b0;
    if (wr && con_sel)
      ie_d = wdata[0];

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          shift_d = wdata[7:0];
          data_d  = wdata[7:0];
          bit_d   = 3'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = even_par(data_q);
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // set beats a same-cycle CON read clear
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    con_val           = 32'd0;
    con_val[CON_IE]   = ie_q;
    con_val[CON_DONE] = done_q;
    con_val[CON_PAR]  = PAR_EN;
    con_val[CON_BUSY] = busy;
  end

  always_comb begin
    rdata = 32'd0;
    if (rd && txd_sel)
      rdata = {24'd0, data_q};
    else if (rd && con_sel)
      rdata = con_val;
  end

  assign tx  = tx_q;
  assign irq = done_q & ie_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph with BAUD_DIV=4.
// Serial frames and bus reads are checked by separate monitors.
module tb_uart_tx_periph;

  localparam int DIV = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] P = 32'h8;
`else
  localparam int NB = 10;
  localparam logic [31:0] P = 32'h0;
`endif
  localparam int FRAME = NB * DIV;
  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] CON = 32'h4000_0020;

  typedef struct {
    logic [7:0] b;
    int         ncyc;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        tx, irq;

  frame_t      fq[$];
  logic [31:0] rq[$];
  int checks = 0;
  int errors = 0;

  uart_tx_periph #(.BAUD_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    rq.push_back(exp);
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int ncyc);
    frame_t f;
    f.b = d;
    f.ncyc = ncyc;
    fq.push_back(f);
    bus_write(TXD, {24'd0, d});
  endtask

  // read monitor: rdata is combinational, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rd === 1'b1) begin
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected got %h want none", rdata);
        end else begin
          chk("rdata", rdata, rq.pop_front());
        end
      end
    end
  end

  // line monitor: every cycle of each frame compared to its expected bit
  initial begin
    frame_t f;
    logic [NB-1:0] bits;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected_frame got start want idle");
        end else begin
          f = fq.pop_front();
          bits = frame_bits(f.b);
          for (int c = 0; c < f.ncyc; c++) begin
            if (c != 0) @(negedge clk);
            chk($sformatf("tx_%h_c%0d", f.b, c), {31'd0, tx},
                {31'd0, bits[c / DIV]});
          end
          if (f.ncyc < FRAME) begin
            @(negedge clk);
            chk("tx_abort_idle", {31'd0, tx}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    bus_read(CON, P);

    send(8'hA5, FRAME);
    bus_read(CON, 32'h10 | P);
    repeat (FRAME - 3) @(posedge clk);
    bus_read(CON, 32'h04 | P);
    bus_read(CON, P);
    bus_read(TXD, 32'hA5);

    bus_write(CON, 32'h1);
    bus_read(CON, 32'h1 | P);
    send(8'h3C, FRAME);
    repeat (FRAME - 1) @(posedge clk);
    #1 chk("irq_before_done", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 chk("irq_done", {31'd0, irq}, 32'd1);
    bus_read(CON, 32'h5 | P);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    bus_read(CON, 32'h1 | P);

    send(8'h11, FRAME);
    bus_write(TXD, 32'hFF);
    bus_read(TXD, 32'h11);
    repeat (FRAME - 6) @(posedge clk);
    bus_write(TXD, 32'hEE);
    bus_read(TXD, 32'h11);
    bus_read(CON, 32'h5 | P);
    repeat (10) @(posedge clk);
    bus_write(CON, 32'h0);

    send(8'h07, FRAME);
    repeat (FRAME + 2) @(posedge clk);
    bus_read(CON, 32'h4 | P);
    bus_read(TXD, 32'h07);

    @(posedge clk); #1;
    rd = 1'b1; wr = 1'b1; addr = CON; wdata = 32'h1;
    rq.push_back(P);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    bus_read(CON, 32'h1 | P);
    bus_write(CON, 32'h1);

    send(8'h5A, 15);
    repeat (14) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    bus_read(CON, P);
    repeat (FRAME) @(posedge clk);
    bus_read(CON, P);
    #1 chk("abort_no_irq", {31'd0, irq}, 32'd0);

    repeat (4) @(posedge clk);
    chk("frames_left", fq.size(), 32'd0);
    chk("reads_left", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
